dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge_if.sv | 27 ++
 rtl/dmem_bridge.sv | 89 ++++++++
 tb/tb_dmem_bridge.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge_if
// Purpose  : Request/response bus between the data-memory bridge and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_bridge_if;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Purpose  : Turns a CPU memory-stage access into one split-phase bus request.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bridge (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_en,
    input  logic [3:0]    memwrite,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    input  logic          pipe_stall,
    output logic [31:0]   rdata,
    output logic          stall,
    dmem_bridge_if.master bus
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [1:0]  w_size;
    logic        w_data_done;

    // Half-word only for aligned lane pairs; odd patterns fall back to word.
    always_comb begin
        w_size = 2'd2;
        case (memwrite)
            4'b0011, 4'b1100:                   w_size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = 2'd0;
            default:                            w_size = 2'd2;
        endcase
    end

    assign w_data_done = ((r_state == c_REQ) && bus.bus_addr_ok && bus.bus_data_ok) ||
                         ((r_state == c_WAIT) && bus.bus_data_ok);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (mem_en) w_next = c_REQ;
            c_REQ:   if (bus.bus_addr_ok) w_next = bus.bus_data_ok ? c_DONE : c_WAIT;
            c_WAIT:  if (bus.bus_data_ok) w_next = c_DONE;
            c_DONE:  if (!pipe_stall) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == c_IDLE) && mem_en) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_wr    <= |memwrite;
                r_size  <= w_size;
            end
            if (w_data_done && !r_wr) begin
                r_rdata <= bus.bus_rdata;
            end
        end
    end

    assign bus.bus_req   = (r_state == c_REQ);
    assign bus.bus_wr    = r_wr;
    assign bus.bus_size  = r_size;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign rdata         = r_rdata;
    assign stall         = ((r_state == c_IDLE) && mem_en) ||
                           (r_state == c_REQ) || (r_state == c_WAIT);
endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bridge
// Purpose  : Directed and random checks of dmem_bridge against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;
    logic        clk;
    logic        rst;
    logic        mem_en;
    logic [3:0]  memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pipe_stall;
    logic [31:0] rdata;
    logic        stall;

    int n_chk;
    int n_err;

    dmem_bridge_if bus_if ();

    dmem_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .mem_en     (mem_en),
        .memwrite   (memwrite),
        .addr       (addr),
        .wdata      (wdata),
        .pipe_stall (pipe_stall),
        .rdata      (rdata),
        .stall      (stall),
        .bus        (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: one access record plus progress flags.
    bit          m_busy;
    bit          m_accepted;
    bit          m_done;
    bit          m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    function automatic logic [1:0] size_of(logic [3:0] we);
        int n = $countones(we);
        if (n == 1) return 2'd0;
        if (we == 4'b0011 || we == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_accepted = 0; m_done = 0; m_wr = 0;
        m_size = 2'd0; m_addr = 32'd0; m_wdata = 32'd0; m_rdata = 32'd0;
    endtask

    task automatic model_update();
        if (!rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (mem_en) begin
                m_busy = 1; m_accepted = 0; m_done = 0;
                m_addr = addr; m_wdata = wdata; m_wr = (memwrite != 4'd0);
                m_size = size_of(memwrite);
            end
        end else if (m_done) begin
            if (!pipe_stall) m_busy = 0;
        end else if (!m_accepted) begin
            if (bus_if.bus_addr_ok) begin
                m_accepted = 1;
                if (bus_if.bus_data_ok) begin
                    m_done = 1;
                    if (!m_wr) m_rdata = bus_if.bus_rdata;
                end
            end
        end else if (bus_if.bus_data_ok) begin
            m_done = 1;
            if (!m_wr) m_rdata = bus_if.bus_rdata;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("stall",     32'(stall),            32'(m_busy ? !m_done : mem_en));
        chk("bus_req",   32'(bus_if.bus_req),   32'(m_busy && !m_accepted));
        chk("bus_wr",    32'(bus_if.bus_wr),    32'(m_wr));
        chk("bus_size",  32'(bus_if.bus_size),  32'(m_size));
        chk("bus_addr",  bus_if.bus_addr,       m_addr);
        chk("bus_wdata", bus_if.bus_wdata,      m_wdata);
        chk("rdata",     rdata,                 m_rdata);
    endtask

    task automatic settle();
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_bus(logic aok, logic dok, logic [31:0] rd);
        bus_if.bus_addr_ok = aok;
        bus_if.bus_data_ok = dok;
        bus_if.bus_rdata   = rd;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b0; mem_en = 0; memwrite = 4'd0; addr = 32'd0; wdata = 32'd0; pipe_stall = 0;
        set_bus(0, 0, 32'd0);
        model_reset();
        settle();
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_req", 32'(bus_if.bus_req), 32'd0);
        chk("reset_size", 32'(bus_if.bus_size), 32'd0);
        tick(); tick();
        rst = 1'b1;

        // Minimum-latency read
        mem_en = 1; memwrite = 4'b0000; addr = 32'h0000_0010;
        settle(); chk("rd_T_stall", 32'(stall), 32'd1);
        tick();
        set_bus(1, 0, 32'h0);
        settle();
        chk("rd_T1_req", 32'(bus_if.bus_req), 32'd1);
        chk("rd_T1_size", 32'(bus_if.bus_size), 32'd2);
        chk("rd_T1_wr", 32'(bus_if.bus_wr), 32'd0);
        chk("rd_T1_stall", 32'(stall), 32'd1);
        tick();
        set_bus(0, 1, 32'hDEAD_BEEF);
        settle(); chk("rd_T2_stall", 32'(stall), 32'd1);
        tick();
        set_bus(0, 0, 32'h0); mem_en = 0;
        settle();
        chk("rd_T3_rdata", rdata, 32'hDEAD_BEEF);
        chk("rd_T3_stall", 32'(stall), 32'd0);
        chk("model_rdata", m_rdata, 32'hDEAD_BEEF);
        tick();

        // Byte store with combined handshake
        mem_en = 1; memwrite = 4'b0100; addr = 32'h20; wdata = 32'h00AB_0000;
        settle(); tick();
        set_bus(1, 1, 32'h1234_5678);
        settle();
        chk("st_wr", 32'(bus_if.bus_wr), 32'd1);
        chk("st_size", 32'(bus_if.bus_size), 32'd0);
        chk("st_req", 32'(bus_if.bus_req), 32'd1);
        tick();
        set_bus(0, 0, 32'h0); mem_en = 0;
        settle();
        chk("st_done_stall", 32'(stall), 32'd0);
        chk("st_rdata_kept", rdata, 32'hDEAD_BEEF);
        tick();

        // Backpressure on a read, then a held DONE stage
        mem_en = 1; memwrite = 4'b0000; addr = 32'h40; wdata = 32'hCAFE_F00D;
        settle(); tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_req", 32'(bus_if.bus_req), 32'd1);
            chk("bp_addr", bus_if.bus_addr, 32'h40);
            tick();
        end
        set_bus(1, 0, 32'h0); settle(); tick();
        set_bus(0, 0, 32'h0); settle();
        chk("bp_wait_req", 32'(bus_if.bus_req), 32'd0);
        chk("bp_wait_stall", 32'(stall), 32'd1);
        tick();
        set_bus(0, 1, 32'h0BAD_F00D); settle(); tick();
        pipe_stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_bus(1, 1, 32'hFFFF_FFFF);
            settle();
            chk("held_req", 32'(bus_if.bus_req), 32'd0);
            chk("held_rdata", rdata, 32'h0BAD_F00D);
            tick();
        end
        pipe_stall = 0; set_bus(0, 0, 32'h0); settle(); tick();
        mem_en = 0; settle();
        chk("held_idle_stall", 32'(stall), 32'd0);
        tick();

        // Reset asserted mid-WAIT, then immediate restart
        mem_en = 1; settle(); tick();
        set_bus(1, 0, 32'h0); settle(); tick();
        set_bus(0, 0, 32'h0); mem_en = 0; settle();
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk("arst_req", 32'(bus_if.bus_req), 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        compare_model();
        tick();
        rst = 1'b1; mem_en = 1; addr = 32'h80; memwrite = 4'b1111;
        settle(); tick();
        settle(); chk("restart_req", 32'(bus_if.bus_req), 32'd1);
        set_bus(1, 1, 32'h0); mem_en = 0; tick();
        set_bus(0, 0, 32'h0); settle(); tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] we_tab [8];
            we_tab = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
            rst        = ($urandom_range(0, 199) != 0);
            mem_en     = ($urandom_range(0, 9) < 7);
            memwrite   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : we_tab[$urandom_range(0, 7)];
            addr       = $urandom;
            wdata      = $urandom;
            pipe_stall = ($urandom_range(0, 9) < 3);
            set_bus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            if (!rst) model_reset();
            settle();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
